// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer:
// states, opcode/funct values, ALUOp codes and datapath mux selects.
package multicycle_sequencer_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;

  // Zero is kept free so an idle cycle drives no ALU request.
  localparam logic [5:0] ALU_ADD   = 6'd1;
  localparam logic [5:0] ALU_SUB   = 6'd2;
  localparam logic [5:0] ALU_XOR   = 6'd3;
  localparam logic [5:0] ALU_SLT   = 6'd4;
  localparam logic [5:0] ALU_FUNCT = 6'd5;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] FLT_NONE    = 2'd0;
  localparam logic [1:0] FLT_ILLEGAL = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT = 2'd2;

  function automatic state_e dispatch(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    logic is_r;
    is_r = (op == OP_R);
    unique case (1'b1)
      is_r && fn == FN_JR:
        dispatch = S_JUMP;
      is_r && (fn == FN_ADD || fn == FN_SUB
               || fn == FN_SLT):
        dispatch = S_EXEC_R;
      op == OP_ADDI || op == OP_XORI:
        dispatch = S_EXEC_I;
      op == OP_LW || op == OP_SW:
        dispatch = S_ADDR;
      op == OP_BEQ || op == OP_BNE:
        dispatch = S_BRANCH;
      op == OP_J || op == OP_JAL:
        dispatch = S_JUMP;
      default:
        dispatch = S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Counts cycles a memory request waits for ready;
// expired_o flags the configured timeout.
module multicycle_sequencer_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [7:0] cnt_q;

  assign expired_o = (cnt_q >= 8'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (clr_i) begin
      cnt_q <= 8'd0;
    end else if (inc_i && !expired_o) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control FSM: per-state strobes, memory
// handshake with timeout, fault parking and retire counter.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [5:0]           alu_op,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           wd_sel,
  output logic                 halted,
  output logic [1:0]           fault,
  output logic [CNT_WIDTH-1:0] retired
);

  state_e               state_q, state_d;
  logic [1:0]           fault_q, fault_d;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 retire;
  logic                 tmr_expired;

  multicycle_sequencer_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (state_d != state_q),
    .inc_i    (mem_req && !mem_ready),
    .expired_o(tmr_expired)
  );

  assign halted  = (state_q == S_HALT);
  assign fault   = fault_q;
  assign retired = retired_q;

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_ALU;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    alu_op    = 6'd0;
    reg_write = 1'b0;
    reg_dst   = DST_RT;
    wd_sel    = WD_ALU;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (tmr_expired) begin
          state_d = S_HALT;
          fault_d = FLT_TIMEOUT;
        end else if (run) begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
        state_d   = dispatch(opcode, funct);
        if (state_d == S_HALT) fault_d = FLT_ILLEGAL;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_R) ? DST_RD : DST_RT;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        if (tmr_expired) begin
          state_d = S_HALT;
          fault_d = FLT_TIMEOUT;
        end else begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wd_sel    = WD_MDR;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        if (tmr_expired) begin
          state_d = S_HALT;
          fault_d = FLT_TIMEOUT;
        end else begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = (opcode == OP_R) ? PC_REG : PC_JUMP;
        if (opcode == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = DST_RA;
          wd_sel    = WD_PC;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RESET;
      fault_q   <= FLT_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: stimulus queues expected strobe events,
// a negedge monitor pops and compares them as they appear.
module tb_multicycle_sequencer;

  typedef struct packed {
    logic [31:0] cyc;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [5:0]  alu_op;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        halted;
    logic [1:0]  fault;
    logic [31:0] retired;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [5:0]  alu_op;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        halted;
  logic [1:0]  fault;
  logic [31:0] retired;

  logic [31:0] cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         sbq[$];
  ev_t         cur;
  logic        halted_d = 1'b0;
  logic        evt;

  multicycle_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .opcode   (opcode),
    .funct    (funct),
    .alu_zero (alu_zero),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .iord     (iord),
    .ir_write (ir_write),
    .pc_write (pc_write),
    .pc_src   (pc_src),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op   (alu_op),
    .reg_write(reg_write),
    .reg_dst  (reg_dst),
    .wd_sel   (wd_sel),
    .halted   (halted),
    .fault    (fault),
    .retired  (retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    cur           = '0;
    cur.cyc       = cyc;
    cur.mem_req   = mem_req;
    cur.mem_we    = mem_we;
    cur.iord      = iord;
    cur.ir_write  = ir_write;
    cur.pc_write  = pc_write;
    cur.pc_src    = pc_src;
    cur.alu_src_a = alu_src_a;
    cur.alu_src_b = alu_src_b;
    cur.alu_op    = alu_op;
    cur.reg_write = reg_write;
    cur.reg_dst   = reg_dst;
    cur.wd_sel    = wd_sel;
    cur.halted    = halted;
    cur.fault     = fault;
    cur.retired   = retired;
  end

  assign evt = (mem_req && mem_ready) || pc_write
            || reg_write || (halted && !halted_d);

  function automatic ev_t ev0(input int c, input int r);
    ev_t e;
    e         = '0;
    e.cyc     = 32'(c);
    e.retired = 32'(r);
    return e;
  endfunction

  task automatic check_ev(input string nm, input ev_t got,
                          input ev_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               nm, got.cyc, got, exp);
    end
  endtask

  task automatic check_now(input string nm, input ev_t exp);
    ev_t g;
    g     = cur;
    g.cyc = 0;
    check_ev(nm, g, exp);
  endtask

  task automatic push_fetch(input int c, input int r);
    ev_t e;
    e           = ev0(c, r);
    e.mem_req   = 1'b1;
    e.ir_write  = 1'b1;
    e.pc_write  = 1'b1;
    e.alu_src_b = 2'd1;
    e.alu_op    = 6'd1;
    sbq.push_back(e);
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                       input logic zero, input int n,
                       input logic [31:0] rdy,
                       input logic [31:0] rn);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      opcode    = op;
      funct     = fn;
      alu_zero  = zero;
      mem_ready = rdy[i];
      run       = rn[i];
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset && evt) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event cyc=%0d got=%h",
                   cyc, cur);
        end else begin
          check_ev("event", cur, sbq.pop_front());
        end
      end
      halted_d = halted;
    end
  end

  initial begin
    ev_t e;
    int  t;
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1;
    opcode = 6'h0; funct = 6'h0; alu_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_outputs", ev0(0, 0));
    reset = 1'b1;
    #1;
    check_now("reset_state_cycle", ev0(0, 0));

    // add
    t = int'(cyc) + 1;
    push_fetch(t, 0);
    e = ev0(t + 3, 0); e.reg_write = 1; e.reg_dst = 2'd1;
    sbq.push_back(e);
    instr(6'h00, 6'h20, 0, 4, 32'h1, '1);

    // lw with 3 wait cycles in MEM_RD
    t = int'(cyc) + 1;
    push_fetch(t, 1);
    e = ev0(t + 6, 1); e.mem_req = 1; e.iord = 1;
    sbq.push_back(e);
    e = ev0(t + 7, 1); e.reg_write = 1; e.wd_sel = 2'd1;
    sbq.push_back(e);
    instr(6'h23, 6'h00, 0, 8, 32'h41, '1);

    // sw
    t = int'(cyc) + 1;
    push_fetch(t, 2);
    e = ev0(t + 3, 2); e.mem_req = 1; e.mem_we = 1; e.iord = 1;
    sbq.push_back(e);
    instr(6'h2b, 6'h00, 0, 4, 32'h9, '1);

    // bne not-zero: taken
    t = int'(cyc) + 1;
    push_fetch(t, 3);
    e = ev0(t + 2, 3); e.pc_write = 1; e.pc_src = 2'd1;
    e.alu_src_a = 1; e.alu_op = 6'd2;
    sbq.push_back(e);
    instr(6'h05, 6'h00, 0, 3, 32'h1, '1);

    // beq not-zero: no PC write
    t = int'(cyc) + 1;
    push_fetch(t, 4);
    instr(6'h04, 6'h00, 0, 3, 32'h1, '1);

    // jal
    t = int'(cyc) + 1;
    push_fetch(t, 5);
    e = ev0(t + 2, 5); e.pc_write = 1; e.pc_src = 2'd2;
    e.reg_write = 1; e.reg_dst = 2'd2; e.wd_sel = 2'd2;
    sbq.push_back(e);
    instr(6'h03, 6'h00, 0, 3, 32'h1, '1);

    // addi with two fetch wait cycles
    t = int'(cyc) + 1;
    push_fetch(t + 2, 6);
    e = ev0(t + 5, 6); e.reg_write = 1;
    sbq.push_back(e);
    instr(6'h08, 6'h00, 0, 6, 32'h4, '1);

    // jr
    t = int'(cyc) + 1;
    push_fetch(t, 7);
    e = ev0(t + 2, 7); e.pc_write = 1; e.pc_src = 2'd3;
    sbq.push_back(e);
    instr(6'h00, 6'h08, 0, 3, 32'h1, '1);

    // lw with run dropped mid-instruction, then idle fetch
    t = int'(cyc) + 1;
    push_fetch(t, 8);
    e = ev0(t + 4, 8); e.mem_req = 1; e.iord = 1;
    sbq.push_back(e);
    e = ev0(t + 5, 8); e.reg_write = 1; e.wd_sel = 2'd1;
    sbq.push_back(e);
    instr(6'h23, 6'h00, 0, 9, 32'h1D1, 32'h3);

    // illegal opcode: fetch resumes at once, then halt
    t = int'(cyc) + 1;
    push_fetch(t, 9);
    e = ev0(t + 2, 9); e.halted = 1; e.fault = 2'd1;
    sbq.push_back(e);
    instr(6'h3f, 6'h00, 0, 4, 32'h9, '1);

    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_now("reset_from_halt", ev0(0, 0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // sub, then fetch timeout
    t = int'(cyc) + 1;
    push_fetch(t, 0);
    e = ev0(t + 3, 0); e.reg_write = 1; e.reg_dst = 2'd1;
    sbq.push_back(e);
    instr(6'h00, 6'h22, 0, 4, 32'h1, '1);

    t = int'(cyc) + 1;
    e = ev0(t + 17, 1); e.halted = 1; e.fault = 2'd2;
    sbq.push_back(e);
    instr(6'h00, 6'h20, 0, 22, 32'h10000, '1);

    e = ev0(0, 1); e.halted = 1; e.fault = 2'd2;
    check_now("halt_frozen", e);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d required=0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
